// File: rtl/dht11_poll_ctrl_if.sv
// Bundle of the signals between the DHT11 poll controller, the sensor core
// and the display/debug path.
interface dht11_poll_ctrl_if;
    logic        en;
    logic        req;
    logic        dht_start;
    logic        dht_done;
    logic        dht_valid;
    logic [31:0] dht_data;
    logic [7:0]  rh_out;
    logic [7:0]  t_out;
    logic        data_valid;
    logic        new_sample;
    logic        fail;
    logic [7:0]  err_cnt;
    logic        busy;
    logic [1:0]  state;

    // Controller side
    modport slave (
        input  en, req, dht_done, dht_valid, dht_data,
        output dht_start, rh_out, t_out, data_valid, new_sample,
               fail, err_cnt, busy, state
    );

    // Requester / sensor-core side
    modport master (
        output en, req, dht_done, dht_valid, dht_data,
        input  dht_start, rh_out, t_out, data_valid, new_sample,
               fail, err_cnt, busy, state
    );
endinterface

// File: rtl/dht11_poll_ctrl.sv
// DHT11 read scheduler: periodic or manual start pulses, minimum gap
// between attempts, per-attempt timeout, bounded retries and a holding
// register for the last good humidity/temperature reading.
module dht11_poll_ctrl #(
    parameter int CLK_PER_MS = 100000,
    parameter int POLL_MS    = 2000,
    parameter int MIN_GAP_MS = 1000,
    parameter int TIMEOUT_MS = 10,
    parameter int MAX_RETRY  = 3
) (
    input  logic             clk,
    input  logic             rst,
    dht11_poll_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // Last cycle index of each timed interval (timers count from 0).
    // poll_tmr is loaded with 1 on the start cycle so that saturation at
    // POLL_LAST lands the next start exactly POLL cycles after the previous.
    localparam logic [31:0] POLL_LAST = 32'(POLL_MS * CLK_PER_MS - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_MS * CLK_PER_MS - 1);
    localparam logic [31:0] GAP_LAST  = 32'(MIN_GAP_MS * CLK_PER_MS - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    logic [1:0]  state_reg, state_next;
    logic [31:0] tmr_reg, tmr_next;
    logic [31:0] poll_tmr_reg, poll_tmr_next;
    logic        pending_reg, pending_next;
    logic        retry_flag_reg, retry_flag_next;
    logic [7:0]  retry_cnt_reg, retry_cnt_next;
    logic [7:0]  rh_reg, rh_next;
    logic [7:0]  t_reg, t_next;
    logic        data_valid_reg, data_valid_next;
    logic        new_sample_reg, new_sample_next;
    logic        fail_reg, fail_next;
    logic [7:0]  err_cnt_reg, err_cnt_next;

    logic        poll_due;
    logic        attempt_ok;
    logic        attempt_bad;

    // Decimal bytes of the reading are not shown on the display path.
    logic        unused_bits;
    assign unused_bits = ^{bus.dht_data[23:16], bus.dht_data[7:0]};

    assign poll_due    = (poll_tmr_reg >= POLL_LAST);
    // A done pulse in the timeout cycle takes priority over the timeout.
    assign attempt_ok  = bus.dht_done & bus.dht_valid;
    assign attempt_bad = bus.dht_done ? ~bus.dht_valid : (tmr_reg == TO_LAST);

    // Next-state, timers, retry bookkeeping and result capture
    always_comb begin
        state_next      = state_reg;
        poll_tmr_next   = poll_due ? poll_tmr_reg : poll_tmr_reg + 32'd1;
        pending_next    = pending_reg;
        retry_flag_next = retry_flag_reg;
        retry_cnt_next  = retry_cnt_reg;
        rh_next         = rh_reg;
        t_next          = t_reg;
        data_valid_next = data_valid_reg;
        new_sample_next = 1'b0;
        fail_next       = fail_reg;
        err_cnt_next    = err_cnt_reg;
        tmr_next        = '0;

        case (state_reg)
            S_IDLE: begin
                if (bus.req || pending_reg || (bus.en && poll_due))
                    state_next = S_START;
            end
            S_START: begin
                pending_next  = 1'b0;
                poll_tmr_next = 32'd1;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                if (attempt_ok) begin
                    rh_next         = bus.dht_data[31:24];
                    t_next          = bus.dht_data[15:8];
                    data_valid_next = 1'b1;
                    new_sample_next = 1'b1;
                    fail_next       = 1'b0;
                    retry_cnt_next  = '0;
                    retry_flag_next = 1'b0;
                    state_next      = S_GAP;
                end else if (attempt_bad) begin
                    if (err_cnt_reg != 8'hFF)
                        err_cnt_next = err_cnt_reg + 8'd1;
                    if (retry_cnt_reg < RETRY_MAX) begin
                        retry_cnt_next  = retry_cnt_reg + 8'd1;
                        retry_flag_next = 1'b1;
                    end else begin
                        fail_next       = 1'b1;
                        retry_cnt_next  = '0;
                        retry_flag_next = 1'b0;
                    end
                    state_next = S_GAP;
                end
            end
            default: begin
                if (tmr_reg == GAP_LAST)
                    state_next = retry_flag_reg ? S_START : S_IDLE;
            end
        endcase

        // Requests arriving while busy are remembered and merged into one read.
        if (bus.req && (state_reg != S_IDLE))
            pending_next = 1'b1;

        // State timer restarts on every state entry and idles at zero.
        if ((state_next == state_reg) && (state_reg != S_IDLE))
            tmr_next = tmr_reg + 32'd1;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            tmr_reg        <= '0;
            poll_tmr_reg   <= '0;
            pending_reg    <= 1'b0;
            retry_flag_reg <= 1'b0;
            retry_cnt_reg  <= '0;
            rh_reg         <= '0;
            t_reg          <= '0;
            data_valid_reg <= 1'b0;
            new_sample_reg <= 1'b0;
            fail_reg       <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            tmr_reg        <= tmr_next;
            poll_tmr_reg   <= poll_tmr_next;
            pending_reg    <= pending_next;
            retry_flag_reg <= retry_flag_next;
            retry_cnt_reg  <= retry_cnt_next;
            rh_reg         <= rh_next;
            t_reg          <= t_next;
            data_valid_reg <= data_valid_next;
            new_sample_reg <= new_sample_next;
            fail_reg       <= fail_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign bus.dht_start  = (state_reg == S_START);
    assign bus.busy       = (state_reg != S_IDLE);
    assign bus.state      = state_reg;
    assign bus.rh_out     = rh_reg;
    assign bus.t_out      = t_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.new_sample = new_sample_reg;
    assign bus.fail       = fail_reg;
    assign bus.err_cnt    = err_cnt_reg;

endmodule
